// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: shared state encoding, PC-mux codes and select-width helper
// for the stack-transfer sequencer.
// Build option: STACK_SEQ_CCR_EN adds a CCR word after the PC on IRQ push
// and before the PC on RTI pop.
package stack_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALL_PUSH,
        RET_POP,
        IRQ_DRAIN,
        IRQ_FRZ,
        IRQ_PUSH,
        RTI_POP
    } state_t;

    localparam logic [1:0] PC_NEXT = 2'd0;
    localparam logic [1:0] PC_RET  = 2'd1;
    localparam logic [1:0] PC_VEC  = 2'd2;
    localparam logic [1:0] PC_CALL = 2'd3;

`ifdef STACK_SEQ_CCR_EN
    localparam int CCR_WORDS = 1;
`else
    localparam int CCR_WORDS = 0;
`endif

    // Select codes run 0 (none), 1..pc_words (PC words), pc_words+1 (CCR).
    function automatic int sel_w(input int pc_words);
        return $clog2(pc_words + 2);
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// stack_seq_if: decode/interrupt requests into the stack sequencer and the
// memory-stage / fetch controls coming back out.
//   requests : call, ret, rti (decode), irq (level), hold (stall in progress)
//   controls : irq_ack, mem_we, mem_re, stack_op, push_sel, pop_sel, pc_sel,
//              flush, freeze_pc, freeze_cu, busy
// master = control-unit side issuing requests, slave = the sequencer.
interface stack_seq_if #(
    parameter int SEL_W = 2
);

    logic             call;
    logic             ret;
    logic             rti;
    logic             irq;
    logic             hold;
    logic             irq_ack;
    logic             mem_we;
    logic             mem_re;
    logic             stack_op;
    logic [SEL_W-1:0] push_sel;
    logic [SEL_W-1:0] pop_sel;
    logic [1:0]       pc_sel;
    logic             flush;
    logic             freeze_pc;
    logic             freeze_cu;
    logic             busy;

    modport master (
        output call, ret, rti, irq, hold,
        input  irq_ack, mem_we, mem_re, stack_op, push_sel, pop_sel, pc_sel,
               flush, freeze_pc, freeze_cu, busy
    );

    modport slave (
        input  call, ret, rti, irq, hold,
        output irq_ack, mem_we, mem_re, stack_op, push_sel, pop_sel, pc_sel,
               flush, freeze_pc, freeze_cu, busy
    );

endinterface

// File: rtl/stack_seq_word_ctr.sv
// stack_seq_word_ctr: loadable up/down word counter with terminal-count flag.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : load load_val_i (has priority over step_i)
//   step_i, up_i : count one step, up when up_i else down
//   term_val_i   : terminal value compared against the current count
//   cnt_d_o      : next count (lets the owner register outputs from it)
//   term_o       : current count equals term_val_i
module stack_seq_word_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         step_i,
    input  logic         up_i,
    input  logic [W-1:0] term_val_i,
    output logic [W-1:0] cnt_d_o,
    output logic         term_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb
        cnt_d = load_i ? load_val_i : step_i ? (up_i ? cnt_q + W'(1) : cnt_q - W'(1)) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign cnt_d_o = cnt_d;
    assign term_o  = cnt_q == term_val_i;

endmodule

// File: rtl/stack_seq.sv
// stack_seq: stack-transfer sequencer for CALL/RET/IRQ/RTI; drives multi-word
// PC (and optional CCR) push/pop through the data-memory port, freezes
// fetch/decode, redirects the PC and acknowledges the interrupt line.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stack_seq_if.slave (requests in, stack/fetch controls out)
// Build option: STACK_SEQ_CCR_EN (via stack_seq_pkg) adds the CCR word.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int PC_WORDS     = 2,
    parameter int DRAIN_CYCLES = 1,
    parameter int SEL_W        = sel_w(PC_WORDS)
) (
    input logic        clk,
    input logic        rst,
    stack_seq_if.slave bus
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [SEL_W-1:0] SEL_ONE = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(PC_WORDS);
    localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(PC_WORDS + CCR_WORDS);
    localparam logic [DW-1:0]    D_MIN   = DW'(DRAIN_CYCLES);

    typedef struct packed {
        logic             mem_we;
        logic             mem_re;
        logic             stack_op;
        logic [SEL_W-1:0] push_sel;
        logic [SEL_W-1:0] pop_sel;
        logic [1:0]       pc_sel;
        logic             flush;
        logic             freeze_pc;
        logic             freeze_cu;
        logic             busy;
    } out_t;

    state_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             seen_q, seen_d;
    logic             ack_q;
    logic             accept;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             ctr_load, ctr_step, ctr_up, ctr_term;
    logic [SEL_W-1:0] ctr_ld_val, ctr_term_val, cnt_d;
    logic             is_push, is_pop;
    out_t             out_q, out_d;

    // Push counts up to its last word, pops count down to word 1.
    assign ctr_term_val = state_q == CALL_PUSH ? SEL_PC : state_q == IRQ_PUSH ? SEL_TOP : SEL_ONE;

    stack_seq_word_ctr #(.W(SEL_W)) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ctr_load),
        .load_val_i (ctr_ld_val),
        .step_i     (ctr_step),
        .up_i       (ctr_up),
        .term_val_i (ctr_term_val),
        .cnt_d_o    (cnt_d),
        .term_o     (ctr_term)
    );

    always_comb begin
        // seen keeps a held-high line from re-latching until it goes low.
        accept     = bus.irq && !pend_q && !seen_q;
        seen_d     = bus.irq && (seen_q || accept);
        pend_d     = pend_q || accept;
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        ctr_load   = 1'b0;
        ctr_ld_val = '0;
        ctr_step   = 1'b0;
        ctr_up     = 1'b0;
        case (state_q)
            IDLE: begin
                ctr_load = 1'b1;
                if (bus.rti) begin
                    state_d    = RTI_POP;
                    ctr_ld_val = SEL_TOP;
                end else if (bus.ret) begin
                    state_d    = RET_POP;
                    ctr_ld_val = SEL_PC;
                end else if (bus.call) begin
                    state_d    = CALL_PUSH;
                    ctr_ld_val = SEL_ONE;
                end else if (pend_d) begin
                    state_d = IRQ_DRAIN;
                    pend_d  = 1'b0;
                    dcnt_d  = DW'(1);
                end
            end
            CALL_PUSH, IRQ_PUSH: begin
                ctr_step = 1'b1;
                ctr_up   = 1'b1;
                if (ctr_term) begin
                    state_d  = IDLE;
                    ctr_load = 1'b1;
                end
            end
            RET_POP, RTI_POP: begin
                ctr_step = 1'b1;
                if (ctr_term) begin
                    state_d  = IDLE;
                    ctr_load = 1'b1;
                end
            end
            IRQ_DRAIN: begin
                if (dcnt_q >= D_MIN && !bus.hold) state_d = IRQ_FRZ;
                else if (dcnt_q < D_MIN)          dcnt_d  = dcnt_q + DW'(1);
            end
            IRQ_FRZ: begin
                state_d    = IRQ_PUSH;
                ctr_load   = 1'b1;
                ctr_ld_val = SEL_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state/count so they come straight off flops.
    always_comb begin
        is_push         = state_d inside {CALL_PUSH, IRQ_PUSH};
        is_pop          = state_d inside {RET_POP, RTI_POP};
        out_d           = '0;
        out_d.busy      = state_d != IDLE;
        out_d.mem_we    = is_push;
        out_d.mem_re    = is_pop;
        out_d.stack_op  = is_push || is_pop;
        out_d.push_sel  = is_push ? cnt_d : '0;
        out_d.pop_sel   = is_pop ? cnt_d : '0;
        out_d.pc_sel    = (state_d == CALL_PUSH && cnt_d == SEL_ONE) ? PC_CALL :
                          (is_pop && cnt_d == SEL_ONE)               ? PC_RET  :
                          (state_d == IRQ_PUSH && cnt_d == SEL_TOP)  ? PC_VEC  : PC_NEXT;
        out_d.flush     = state_d == CALL_PUSH && cnt_d == SEL_ONE;
        out_d.freeze_pc = is_pop || state_d inside {IRQ_FRZ, IRQ_PUSH};
        out_d.freeze_cu = is_pop || state_d == IRQ_PUSH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            seen_q  <= 1'b0;
            ack_q   <= 1'b0;
            dcnt_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seen_q  <= seen_d;
            ack_q   <= accept;
            dcnt_q  <= dcnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.irq_ack   = ack_q;
    assign bus.mem_we    = out_q.mem_we;
    assign bus.mem_re    = out_q.mem_re;
    assign bus.stack_op  = out_q.stack_op;
    assign bus.push_sel  = out_q.push_sel;
    assign bus.pop_sel   = out_q.pop_sel;
    assign bus.pc_sel    = out_q.pc_sel;
    assign bus.flush     = out_q.flush;
    assign bus.freeze_pc = out_q.freeze_pc;
    assign bus.freeze_cu = out_q.freeze_cu;
    assign bus.busy      = out_q.busy;

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: two sequencer builds (PC_WORDS=2/DRAIN=1 and PC_WORDS=3/DRAIN=2)
// driven by shared stimulus; each has a sequence-plan reference model feeding
// an expected-output queue and a monitor comparing every cycle.
module tb_stack_seq;
    import stack_seq_pkg::*;

    typedef struct packed {
        logic       irq_ack;
        logic       mem_we;
        logic       mem_re;
        logic       stack_op;
        logic [3:0] push_sel;
        logic [3:0] pop_sel;
        logic [1:0] pc_sel;
        logic       flush;
        logic       freeze_pc;
        logic       freeze_cu;
        logic       busy;
    } vec_t;

    localparam int K_CALL  = 0;
    localparam int K_POP   = 1;
    localparam int K_FRZ   = 2;
    localparam int K_PUSH  = 3;
    localparam int K_DRAIN = 4;

    logic clk = 1'b0;
    logic rst;
    logic call, ret, rti, irq, hold;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Expected outputs of one sequence cycle; k is the word being moved.
    function automatic vec_t mk(input int kind, input int k, input int last);
        vec_t v = '0;
        v.busy = 1'b1;
        case (kind)
            K_CALL: begin
                v.mem_we   = 1'b1;
                v.stack_op = 1'b1;
                v.push_sel = 4'(k);
                v.pc_sel   = k == 1 ? 2'd3 : 2'd0;
                v.flush    = k == 1;
            end
            K_POP: begin
                v.mem_re    = 1'b1;
                v.stack_op  = 1'b1;
                v.freeze_pc = 1'b1;
                v.freeze_cu = 1'b1;
                v.pop_sel   = 4'(k);
                v.pc_sel    = k == 1 ? 2'd1 : 2'd0;
            end
            K_FRZ: v.freeze_pc = 1'b1;
            K_PUSH: begin
                v.mem_we    = 1'b1;
                v.stack_op  = 1'b1;
                v.freeze_pc = 1'b1;
                v.freeze_cu = 1'b1;
                v.push_sel  = 4'(k);
                v.pc_sel    = k == last ? 2'd2 : 2'd0;
            end
            default: ;
        endcase
        return v;
    endfunction

    task automatic chk_zero(input vec_t a, input string nm);
        n_chk++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h, expected 0", nm, a);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int PCW = g == 0 ? 2 : 3;
        localparam int DRN = g == 0 ? 1 : 2;
        localparam int SW  = sel_w(PCW);

        stack_seq_if #(.SEL_W(SW)) bus ();

        assign bus.call = call;
        assign bus.ret  = ret;
        assign bus.rti  = rti;
        assign bus.irq  = irq;
        assign bus.hold = hold;

        stack_seq #(.PC_WORDS(PCW), .DRAIN_CYCLES(DRN)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        vec_t act;
        assign act = '{irq_ack: bus.irq_ack, mem_we: bus.mem_we, mem_re: bus.mem_re,
                       stack_op: bus.stack_op, push_sel: 4'(bus.push_sel),
                       pop_sel: 4'(bus.pop_sel), pc_sel: bus.pc_sel, flush: bus.flush,
                       freeze_pc: bus.freeze_pc, freeze_cu: bus.freeze_cu, busy: bus.busy};

        vec_t plan[$];
        vec_t expq[$];
        vec_t v, e;
        logic pend, seen, draining, was_busy, acc;
        int   dcnt;

        // Reference model: when idle, pick a request and queue its whole cycle plan.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                plan.delete();
                expq.delete();
                {pend, seen, draining, was_busy} = '0;
                dcnt = 0;
            end else begin
                acc  = irq && !pend && !seen;
                seen = irq && (seen || acc);
                pend = pend || acc;
                if (!was_busy) begin
                    if (rti)
                        for (int k = PCW + CCR_WORDS; k >= 1; k--) plan.push_back(mk(K_POP, k, 1));
                    else if (ret)
                        for (int k = PCW; k >= 1; k--) plan.push_back(mk(K_POP, k, 1));
                    else if (call)
                        for (int k = 1; k <= PCW; k++) plan.push_back(mk(K_CALL, k, PCW));
                    else if (pend) begin
                        draining = 1'b1;
                        dcnt = 1;
                        pend = 1'b0;
                    end
                end else if (draining) begin
                    if (dcnt >= DRN && !hold) begin
                        draining = 1'b0;
                        plan.push_back(mk(K_FRZ, 0, 0));
                        for (int k = 1; k <= PCW + CCR_WORDS; k++)
                            plan.push_back(mk(K_PUSH, k, PCW + CCR_WORDS));
                    end else dcnt++;
                end
                v = draining ? mk(K_DRAIN, 0, 0) : plan.size() > 0 ? plan.pop_front() : vec_t'(0);
                v.irq_ack = acc;
                was_busy = v.busy;
                expq.push_back(v);
            end
        end

        always @(negedge clk) begin
            if (!rst && expq.size() > 0) begin
                e = expq.pop_front();
                n_chk++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL lane%0d outputs t=%0t: got %h, expected %h", g, $time, act, e);
                end
            end
        end
    end

    initial begin
        logic found;
        {call, ret, rti, irq, hold} = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero(lane[0].act, "reset_lane0");
        chk_zero(lane[1].act, "reset_lane1");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        call = 1'b1;
        @(negedge clk) call = 1'b0;
        repeat (8) @(negedge clk);
        ret = 1'b1;
        @(negedge clk) ret = 1'b0;
        repeat (8) @(negedge clk);
        irq = 1'b1;
        hold = 1'b1;
        repeat (3) @(negedge clk);
        {irq, hold} = '0;
        repeat (15) @(negedge clk);
        irq = 1'b1;
        call = 1'b1;
        @(negedge clk) {irq, call} = '0;
        repeat (20) @(negedge clk);
        rti = 1'b1;
        @(negedge clk) rti = 1'b0;
        repeat (10) @(negedge clk);
        irq = 1'b1;
        @(negedge clk) irq = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = lane[0].act.push_sel == 4'd2 && lane[0].act.freeze_pc;
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL irq_push2_wait: got timeout, expected second IRQ push");
        end
        #2 rst = 1'b1;
        #1;
        chk_zero(lane[0].act, "midseq_reset_lane0");
        chk_zero(lane[1].act, "midseq_reset_lane1");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            call = $urandom_range(9) == 0;
            ret  = $urandom_range(11) == 0;
            rti  = $urandom_range(13) == 0;
            if ($urandom_range(7) == 0) irq = !irq;
            hold = $urandom_range(3) == 0;
        end
        {call, ret, rti, irq, hold} = '0;
        repeat (40) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
